// File: rtl/logic32_pkg.sv
// rtl/logic32_pkg.sv - shared types, opcodes and evaluation helper for the 32-bit logic stage
package logic32_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        LOGIC_AND = 2'b00,
        LOGIC_OR  = 2'b01,
        LOGIC_XOR = 2'b10,
        LOGIC_NOR = 2'b11
    } logic_op_e;

    // One queued operand beat.
    typedef struct packed {
        logic_op_e          op;
        logic [WORD_W-1:0]  a;
        logic [WORD_W-1:0]  b;
    } entry_t;

    function automatic logic [WORD_W-1:0] logic_eval(input entry_t e);
        logic [WORD_W-1:0] r;
        case (e.op)
            LOGIC_AND: r = e.a & e.b;
            LOGIC_OR:  r = e.a | e.b;
            LOGIC_XOR: r = e.a ^ e.b;
            default:   r = ~(e.a | e.b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic32_stage_if.sv
// rtl/logic32_stage_if.sv - operand-in / result-out handshake bundle for logic32_stage
// Purpose: groups the upstream beat handshake, downstream result handshake and occupancy.
// Ports (signals): in_valid/in_ready/in_a/in_b/in_op, out_valid/out_ready/out_answer,
//   fifo_count, and out_zero when LOGIC32_STAGE_ZERO_FLAG_EN is defined.
// master = producer/consumer side (testbench or datapath), slave = the stage.
interface logic32_stage_if #(
    parameter int FIFO_DEPTH = 4
);
    import logic32_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_a;
    logic [WORD_W-1:0] in_b;
    logic [1:0]        in_op;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_answer;
    logic [CNT_W-1:0]  fifo_count;
`ifdef LOGIC32_STAGE_ZERO_FLAG_EN
    logic              out_zero;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_answer, fifo_count, out_zero
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_answer, fifo_count, out_zero
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_answer, fifo_count
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_answer, fifo_count
    );
`endif

endinterface

// File: rtl/operand_fifo.sv
// rtl/operand_fifo.sv - power-of-two operand FIFO with occupancy counter
// Ports: clk, reset (async, active-high), push_i/push_data_i, pop_i/pop_data_o,
//   full_o, empty_o, count_o. Push while full and pop while empty are ignored.
module operand_fifo
    import logic32_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    output entry_t           pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Full blocks a push even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/logic32_stage.sv
// rtl/logic32_stage.sv - registered, flow-controlled AND/OR/XOR/NOR stage
// Ports: clk, reset (async, active-high), bus (logic32_stage_if.slave: operand
//   handshake in, result handshake out, fifo_count). Optional feature macro
//   LOGIC32_STAGE_ZERO_FLAG_EN adds the registered out_zero flag.
module logic32_stage
    import logic32_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    logic32_stage_if.slave  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    entry_t            push_entry;
    entry_t            head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [WORD_W-1:0] head_result;
    logic              load;

    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_answer_q, out_answer_d;

    assign push_entry = '{op: logic_op_e'(bus.in_op), a: bus.in_a, b: bus.in_b};

    operand_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (bus.in_valid),
        .push_data_i (push_entry),
        .pop_i       (load),
        .pop_data_o  (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign head_result = logic_eval(head_entry);

    // Load when there is a head and the output register is free or draining now.
    assign load = !fifo_empty && (!out_valid_q || bus.out_ready);

    always_comb begin
        out_valid_d  = out_valid_q;
        out_answer_d = out_answer_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_answer_d = head_result;
        end else if (bus.out_ready && out_valid_q) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_answer_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_answer_q <= out_answer_d;
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_answer = out_answer_q;
    assign bus.fifo_count = fifo_count;

`ifdef LOGIC32_STAGE_ZERO_FLAG_EN
    logic out_zero_q, out_zero_d;

    always_comb begin
        out_zero_d = out_zero_q;
        if (load) out_zero_d = (head_result == '0);
    end

    // Reset value 1 matches the all-zero reset answer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_zero_q <= 1'b1;
        else       out_zero_q <= out_zero_d;
    end

    assign bus.out_zero = out_zero_q;
`endif

endmodule

// File: tb/tb_logic32_stage.sv
// tb/tb_logic32_stage.sv - self-checking bench for logic32_stage
module tb_logic32_stage;

    logic clk;
    logic reset;

    logic32_stage_if #(.FIFO_DEPTH(4)) bus ();

    logic32_stage #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int deq_cnt = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        z;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: result straight from the opcode definition.
    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0: return a & b;
            2'd1: return a | b;
            2'd2: return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // One clock: decide handshakes at negedge, update scoreboard, return #1 after posedge.
    task automatic cycle();
        logic acc, deq, hold;
        logic [31:0] held;
        @(negedge clk);
        acc  = bus.in_valid && bus.in_ready;
        deq  = bus.out_valid && bus.out_ready;
        hold = bus.out_valid && !bus.out_ready;
        held = bus.out_answer;
        if (deq) begin
            deq_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", bus.out_answer, 32'hxxxxxxxx);
            end else begin
                chk("result_order", bus.out_answer, exp_q.pop_front());
            end
        end
        if (acc) exp_q.push_back(ref_op(bus.in_op, bus.in_a, bus.in_b));
        @(posedge clk);
        #1;
        if (hold) begin
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_answer", bus.out_answer, held);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    task automatic drain();
        int n;
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        bus.out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 30) begin
            cycle();
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
        chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int base;
        vt[0] = '{2'd3, 32'hFFFFFFFF, 32'h0000ABCD, 32'h00000000, 1'b1};
        vt[1] = '{2'd3, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b1};
        vt[2] = '{2'd2, 32'hABCD6789, 32'h1111AAAA, 32'hBADCCD23, 1'b0};
        vt[3] = '{2'd0, 32'hABCD6789, 32'h1111AAAA, 32'h01012288, 1'b0};
        vt[4] = '{2'd1, 32'hFFF4FFFF, 32'h00000001, 32'hFFF4FFFF, 1'b0};
        vt[5] = '{2'd0, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1'b0};
        vt[6] = '{2'd1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
        vt[7] = '{2'd3, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};

        reset = 1'b1;
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        bus.out_ready = 1'b0;
        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_count", {29'd0, bus.fifo_count}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_answer", bus.out_answer, 32'd0);
`ifdef LOGIC32_STAGE_ZERO_FLAG_EN
        chk("rst_zero", {31'd0, bus.out_zero}, 32'd1);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors: one beat each, minimum latency checked.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vt[i].op, vt[i].a, vt[i].b);
            cycle();
            drive(1'b0, 2'd0, 32'd0, 32'd0);
            chk("lat_not_yet", {31'd0, bus.out_valid}, 32'd0);
            cycle();
            chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("vec%0d_answer", i), bus.out_answer, vt[i].exp);
`ifdef LOGIC32_STAGE_ZERO_FLAG_EN
            chk($sformatf("vec%0d_zero", i), {31'd0, bus.out_zero}, {31'd0, vt[i].z});
`endif
            cycle();
        end
        drain();

        // Backpressure: fill output register plus four FIFO entries.
        bus.out_ready = 1'b0;
        base = deq_cnt;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd1, 32'h100 + i, 32'h0);
            cycle();
            chk($sformatf("bp_count%0d", i), {29'd0, bus.fifo_count}, (i == 0) ? 32'd1 : i);
        end
        chk("bp_full_ready", {31'd0, bus.in_ready}, 32'd0);
        drive(1'b1, 2'd1, 32'hDEAD, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_full_count", {29'd0, bus.fifo_count}, 32'd4);
        end
        drain();
        chk("bp_results", deq_cnt - base, 32'd5);

        // Streaming: 16 back-to-back beats with out_ready held high.
        bus.out_ready = 1'b1;
        base = deq_cnt;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom);
            chk("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
            cycle();
            if (i > 0) chk("stream_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        cycle();
        chk("stream_last_valid", {31'd0, bus.out_valid}, 32'd1);
        drain();
        chk("stream_results", deq_cnt - base, 32'd16);

        // Simultaneous push/pop at count 2 across three pointer wraps.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd2, 32'h5A5A0000 + i, 32'h0000FFFF);
            cycle();
        end
        chk("pp_count_start", {29'd0, bus.fifo_count}, 32'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom);
            cycle();
            chk("pp_count", {29'd0, bus.fifo_count}, 32'd2);
        end
        drain();

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom);
            bus.out_ready = $urandom_range(0, 2) != 0;
            cycle();
        end
        drain();

        // Reset mid-stream: output register full, three beats queued.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd1, 32'hC0DE0000 + i, 32'h1);
            cycle();
        end
        chk("mid_count", {29'd0, bus.fifo_count}, 32'd3);
        chk("mid_valid", {31'd0, bus.out_valid}, 32'd1);
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_count", {29'd0, bus.fifo_count}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_rst_answer", bus.out_answer, 32'd0);
`ifdef LOGIC32_STAGE_ZERO_FLAG_EN
        chk("mid_rst_zero", {31'd0, bus.out_zero}, 32'd1);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        base = deq_cnt;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        chk("post_rst_results", deq_cnt - base, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
